// File: rtl/ebus_dev_port.sv
// EBUS device-side responder: decodes CONO/CONI/DATAO/DATAI and PI cycles for one
// controller, drives this device's data-mux entry and the one-hot PI request lines.
package ebus_pkg;
    typedef enum logic [0:2] {
        ebusfCONO     = 3'b000,
        ebusfCONI     = 3'b001,
        ebusfDATAO    = 3'b010,
        ebusfDATAI    = 3'b011,
        ebusfPIserved = 3'b100,
        ebusfPIaddrIn = 3'b101,
        ebusfUNUSED6  = 3'b110,
        ebusfUNUSED7  = 3'b111
    } tEBUSfunction;

    typedef struct packed {
        logic        driving;
        logic [0:35] data;
    } tEBUSdriver;
endpackage

module ebus_dev_port
    import ebus_pkg::*;
#(
    parameter logic [0:6] DEV_CS = 7'o060
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:6]   ebus_cs,
    input  tEBUSfunction ebus_func,
    input  logic         ebus_demand,
    input  logic [0:35]  ebus_data_in,
    input  logic         ebus_reset,
    output tEBUSdriver   drv,
    output logic         ebus_ack,
    output logic         ebus_xfer,
    output logic [0:7]   ebus_pi,
    output logic [0:35]  cono_data,
    output logic [0:35]  datao_data,
    output logic         cono_stb,
    output logic         datao_stb,
    input  logic [0:35]  coni_status,
    input  logic [0:35]  datai_data,
    input  logic         datai_valid,
    output logic         datai_taken,
    input  logic [0:2]   pi_level,
    input  logic [0:35]  pi_vector,
    output logic         pi_served_stb,
    output logic         dev_reset
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]   state;
    tEBUSfunction func_q;
    logic [0:35]  rd_q;
    logic         ebus_reset_q;
    logic         io_func;
    logic         pi_func;
    logic         hit;

    // PI functions match on the level we are requesting, not on our select code.
    always_comb begin
        io_func = ebus_func inside {ebusfCONO, ebusfCONI, ebusfDATAO, ebusfDATAI};
        pi_func = ebus_func inside {ebusfPIserved, ebusfPIaddrIn};
        hit     = ebus_demand &&
                  ((io_func && (ebus_cs == DEV_CS)) ||
                   (pi_func && (pi_level != 3'd0) && (ebus_cs[4:6] == pi_level)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            func_q        <= ebusfCONO;
            rd_q          <= '0;
            cono_data     <= '0;
            datao_data    <= '0;
            cono_stb      <= 1'b0;
            datao_stb     <= 1'b0;
            datai_taken   <= 1'b0;
            pi_served_stb <= 1'b0;
            ebus_pi       <= '0;
            ebus_reset_q  <= 1'b0;
            dev_reset     <= 1'b0;
        end else begin
            cono_stb      <= 1'b0;
            datao_stb     <= 1'b0;
            datai_taken   <= 1'b0;
            pi_served_stb <= 1'b0;
            ebus_reset_q  <= ebus_reset;
            dev_reset     <= ebus_reset & ~ebus_reset_q;
            if (ebus_reset) begin
                state   <= IDLE;
                ebus_pi <= '0;
            end else begin
                ebus_pi <= (pi_level == 3'd0) ? 8'h00 : (8'h80 >> pi_level);
                case (state)
                    IDLE: begin
                        if (hit) begin
                            func_q <= ebus_func;
                            state  <= DONE;
                            case (ebus_func)
                                ebusfCONO: begin
                                    cono_data <= ebus_data_in;
                                    cono_stb  <= 1'b1;
                                end
                                ebusfDATAO: begin
                                    datao_data <= ebus_data_in;
                                    datao_stb  <= 1'b1;
                                end
                                ebusfCONI:     rd_q <= coni_status;
                                ebusfPIaddrIn: rd_q <= pi_vector;
                                ebusfPIserved: pi_served_stb <= 1'b1;
                                ebusfDATAI: begin
                                    if (datai_valid) begin
                                        rd_q        <= datai_data;
                                        datai_taken <= 1'b1;
                                    end else begin
                                        state <= WAIT;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                    // Losing demand beats a simultaneous datai_valid: the EBOX has gone.
                    WAIT: begin
                        if (!ebus_demand) begin
                            state <= IDLE;
                        end else if (datai_valid) begin
                            rd_q        <= datai_data;
                            datai_taken <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        if (!ebus_demand) state <= IDLE;
                    end
                    ACTIVE: state <= IDLE;
                endcase
            end
        end
    end

    assign ebus_ack  = (state == WAIT) || (state == DONE);
    assign ebus_xfer = (state == DONE);

    always_comb begin
        drv.driving = (state == DONE) && (func_q inside {ebusfCONI, ebusfDATAI, ebusfPIaddrIn});
        drv.data    = drv.driving ? rd_q : '0;
    end

endmodule

// File: tb/tb_ebus_dev_port.sv
// Randomized transaction-level bench for ebus_dev_port; expected responses come
// from the bus rules (hit decode, latched words, one-hot PI) rather than the RTL.
module tb_ebus_dev_port;
    import ebus_pkg::*;

    localparam logic [0:6] DEV_CS = 7'o060;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:6]   ebus_cs = '0;
    tEBUSfunction ebus_func = ebusfCONO;
    logic         ebus_demand = 1'b0;
    logic [0:35]  ebus_data_in = '0;
    logic         ebus_reset = 1'b0;
    tEBUSdriver   drv;
    logic         ebus_ack, ebus_xfer;
    logic [0:7]   ebus_pi;
    logic [0:35]  cono_data, datao_data;
    logic         cono_stb, datao_stb;
    logic [0:35]  coni_status = '0;
    logic [0:35]  datai_data = '0;
    logic         datai_valid = 1'b0;
    logic         datai_taken;
    logic [0:2]   pi_level = '0;
    logic [0:35]  pi_vector = '0;
    logic         pi_served_stb, dev_reset;

    int n_cmp = 0;
    int n_err = 0;

    ebus_dev_port #(.DEV_CS(DEV_CS)) dut (
        .clk(clk), .rst_n(rst_n), .ebus_cs(ebus_cs), .ebus_func(ebus_func),
        .ebus_demand(ebus_demand), .ebus_data_in(ebus_data_in), .ebus_reset(ebus_reset),
        .drv(drv), .ebus_ack(ebus_ack), .ebus_xfer(ebus_xfer), .ebus_pi(ebus_pi),
        .cono_data(cono_data), .datao_data(datao_data), .cono_stb(cono_stb),
        .datao_stb(datao_stb), .coni_status(coni_status), .datai_data(datai_data),
        .datai_valid(datai_valid), .datai_taken(datai_taken), .pi_level(pi_level),
        .pi_vector(pi_vector), .pi_served_stb(pi_served_stb), .dev_reset(dev_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    function automatic logic [0:7] onehot(input logic [0:2] lvl);
        logic [0:7] r;
        r = '0;
        if (lvl != 3'd0) r[lvl] = 1'b1;
        return r;
    endfunction

    function automatic bit spec_hit(input tEBUSfunction f, input logic [0:6] cs, input logic [0:2] lvl);
        case (f)
            ebusfCONO, ebusfCONI, ebusfDATAO, ebusfDATAI: return cs == DEV_CS;
            ebusfPIserved, ebusfPIaddrIn:                 return (lvl != 3'd0) && (cs[4:6] == lvl);
            default:                                      return 1'b0;
        endcase
    endfunction

    // One clock; the PI lines must follow the level presented before the edge.
    task automatic step();
        logic [0:7] exp_pi;
        exp_pi = ebus_reset ? 8'h00 : onehot(pi_level);
        @(posedge clk);
        #1;
        chk("ebus_pi", 64'(ebus_pi), 64'(exp_pi));
        if (!drv.driving) chk("idle_data", 64'(drv.data), 64'(0));
    endtask

    // stbs order: {cono_stb, datao_stb, datai_taken, pi_served_stb}
    task automatic expect_outs(input string tag, input logic ack, input logic xfer,
                               input logic driving, input logic [0:35] data, input logic [3:0] stbs);
        chk({tag, ".ack"}, 64'(ebus_ack), 64'(ack));
        chk({tag, ".xfer"}, 64'(ebus_xfer), 64'(xfer));
        chk({tag, ".driving"}, 64'(drv.driving), 64'(driving));
        chk({tag, ".data"}, 64'(drv.data), 64'(data));
        chk({tag, ".stb"}, 64'({cono_stb, datao_stb, datai_taken, pi_served_stb}), 64'(stbs));
    endtask

    task automatic run_txn(input tEBUSfunction f, input logic [0:6] cs, input logic [0:35] wd,
                           input logic [0:35] dv, input int wait_n, input bit abort, input int hold);
        logic [0:35] rd;
        logic [3:0]  stb;
        bit          hit, rdfn;
        hit = spec_hit(f, cs, pi_level);
        coni_status  = rnd36();
        pi_vector    = rnd36();
        datai_data   = (wait_n == 0) ? dv : rnd36();
        datai_valid  = (wait_n == 0);
        ebus_func    = f;
        ebus_cs      = cs;
        ebus_data_in = wd;
        ebus_demand  = 1'b1;
        rd   = (f == ebusfCONI) ? coni_status : (f == ebusfPIaddrIn) ? pi_vector : dv;
        rdfn = f inside {ebusfCONI, ebusfDATAI, ebusfPIaddrIn};
        case (f)
            ebusfCONO:     stb = 4'b1000;
            ebusfDATAO:    stb = 4'b0100;
            ebusfDATAI:    stb = 4'b0010;
            ebusfPIserved: stb = 4'b0001;
            default:       stb = 4'b0000;
        endcase
        step();
        // Disturb the sources so only latched copies can match.
        ebus_data_in = rnd36();
        coni_status  = rnd36();
        pi_vector    = rnd36();
        datai_valid  = 1'b0;
        datai_data   = rnd36();
        if (!hit) begin
            expect_outs("miss", 0, 0, 0, '0, 4'b0);
            step();
            expect_outs("miss2", 0, 0, 0, '0, 4'b0);
            ebus_demand = 1'b0;
            step();
            return;
        end
        if (f == ebusfDATAI && wait_n > 0) begin
            for (int k = 0; k < wait_n; k++) begin
                expect_outs("wait", 1, 0, 0, '0, 4'b0);
                if (k == wait_n - 1) begin
                    datai_data = dv;
                    if (abort) begin
                        ebus_demand = 1'b0;
                        datai_valid = 1'($urandom_range(0, 1));
                    end else begin
                        datai_valid = 1'b1;
                    end
                end
                step();
            end
            datai_valid = 1'b0;
            datai_data  = rnd36();
            if (abort) begin
                expect_outs("abort", 0, 0, 0, '0, 4'b0);
                step();
                expect_outs("abort2", 0, 0, 0, '0, 4'b0);
                return;
            end
        end
        expect_outs("done", 1, 1, rdfn, rdfn ? rd : 36'h0, stb);
        if (f == ebusfCONO)  chk("cono_data", 64'(cono_data), 64'(wd));
        if (f == ebusfDATAO) chk("datao_data", 64'(datao_data), 64'(wd));
        for (int h = 0; h < hold; h++) begin
            step();
            expect_outs("hold", 1, 1, rdfn, rdfn ? rd : 36'h0, 4'b0);
        end
        ebus_demand = 1'b0;
        step();
        expect_outs("release", 0, 0, 0, '0, 4'b0);
        if (f == ebusfCONO)  chk("cono_kept", 64'(cono_data), 64'(wd));
        if (f == ebusfDATAO) chk("datao_kept", 64'(datao_data), 64'(wd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:35]  keep;
        tEBUSfunction f;
        logic [0:6]   cs;

        #12;
        expect_outs("reset", 0, 0, 0, '0, 4'b0);
        chk("reset.cono_data", 64'(cono_data), 64'(0));
        chk("reset.datao_data", 64'(datao_data), 64'(0));
        chk("reset.pi", 64'(ebus_pi), 64'(0));
        chk("reset.dev_reset", 64'(dev_reset), 64'(0));
        rst_n = 1'b1;
        step();

        run_txn(ebusfCONO, DEV_CS, 36'o123456_654321, '0, 0, 0, 1);

        ebus_func = ebusfDATAO; ebus_cs = DEV_CS + 7'd1; ebus_demand = 1'b1;
        ebus_data_in = rnd36();
        for (int i = 0; i < 10; i++) begin
            step();
            expect_outs("wrong_cs", 0, 0, 0, '0, 4'b0);
        end
        ebus_demand = 1'b0;
        step();

        run_txn(ebusfDATAI, DEV_CS, '0, 36'o777000_000777, 5, 0, 1);
        run_txn(ebusfDATAI, DEV_CS, '0, rnd36(), 3, 1, 0);

        pi_level = 3'd5;
        step();
        chk("pi5", 64'(ebus_pi), 64'(8'b00000100));
        run_txn(ebusfPIaddrIn, {4'b0000, 3'd5}, '0, '0, 0, 0, 2);
        run_txn(ebusfPIserved, {4'b0000, 3'd3}, '0, '0, 0, 0, 0);
        run_txn(ebusfPIserved, {4'b0101, 3'd5}, '0, '0, 0, 0, 0);

        // EBUS reset while a CONI is being driven
        ebus_func = ebusfCONI; ebus_cs = DEV_CS; ebus_demand = 1'b1; coni_status = rnd36();
        step();
        chk("pre_ebrst.xfer", 64'(ebus_xfer), 64'(1));
        ebus_reset = 1'b1;
        step();
        expect_outs("ebrst", 0, 0, 0, '0, 4'b0);
        chk("ebrst.dev_reset", 64'(dev_reset), 64'(1));
        ebus_demand = 1'b0;
        step();
        chk("ebrst.dev_reset_once", 64'(dev_reset), 64'(0));
        ebus_reset = 1'b0;
        step();
        chk("ebrst.dev_reset_off", 64'(dev_reset), 64'(0));

        // EBUS reset colliding with a CONO hit
        keep = cono_data;
        ebus_func = ebusfCONO; ebus_cs = DEV_CS; ebus_data_in = ~keep;
        ebus_demand = 1'b1; ebus_reset = 1'b1;
        step();
        expect_outs("rst_vs_hit", 0, 0, 0, '0, 4'b0);
        chk("rst_vs_hit.cono_data", 64'(cono_data), 64'(keep));
        ebus_demand = 1'b0; ebus_reset = 1'b0;
        step();

        // Asynchronous reset in the middle of a DATAI wait
        ebus_func = ebusfDATAI; ebus_cs = DEV_CS; datai_valid = 1'b0; ebus_demand = 1'b1;
        step();
        step();
        chk("pre_rst.ack", 64'(ebus_ack), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        expect_outs("async_rst", 0, 0, 0, '0, 4'b0);
        chk("async_rst.cono_data", 64'(cono_data), 64'(0));
        chk("async_rst.datao_data", 64'(datao_data), 64'(0));
        chk("async_rst.pi", 64'(ebus_pi), 64'(0));
        ebus_demand = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) pi_level = 3'($urandom_range(0, 7));
            f = tEBUSfunction'(3'($urandom_range(0, 7)));
            case ($urandom_range(0, 3))
                0, 1:    cs = DEV_CS;
                2:       cs = 7'($urandom());
                default: cs = {4'($urandom()), pi_level};
            endcase
            run_txn(f, cs, rnd36(), rnd36(), (f == ebusfDATAI) ? int'($urandom_range(0, 4)) : 0,
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ebus_dev_port.md
# ebus_dev_port

Device-side EBUS transaction responder for a KL10 I/O device model. It selects on controller select plus function. It answers CONO, CONI, DATAO, DATAI, PI-served and PI-address-in cycles with ack/xfer, and presents its read data as one driver entry for the EBUS data mux. It sits directly downstream of the EBOX EBUS master and upstream of the device register/logic core. It also turns the device's interrupt level into the EBUS PI request lines.

## Interface

Parameters:
- DEV_CS, 7'o060: controller select code this port answers to.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Asynchronous, active-low.
- ebus_cs, in, [0:6]: controller select, or PI level in cs[4:6] for PI functions.
- ebus_func, in, [0:2]: tEBUSfunction.
- ebus_demand, in, 1: EBOX demand.
- ebus_data_in, in, [0:35]: EBUS data bus (mux output).
- ebus_reset, in, 1: EBUS reset.
- drv, out, tEBUSdriver: this port's data/driving entry for the EBUS mux.
- ebus_ack, out, 1: acknowledge.
- ebus_xfer, out, 1: transfer done.
- ebus_pi, out, [0:7]: PI request, one-hot by level.
- cono_data / datao_data, out, [0:35]: captured write words.
- cono_stb / datao_stb, out, 1: one-cycle write strobes.
- coni_status, in, [0:35]: device status word.
- datai_data, in, [0:35]: device read word.
- datai_valid, in, 1: datai_data is ready.
- datai_taken, out, 1: one-cycle pulse when a DATAI completes.
- pi_level, in, [0:2]: requested PI level; 0 means no request.
- pi_vector, in, [0:35]: word returned on PI-address-in.
- pi_served_stb, out, 1: one-cycle pulse when PI-served is acknowledged.
- dev_reset, out, 1: one-cycle pulse on EBUS reset.

## Operation

- FSM states are IDLE, ACTIVE, WAIT and DONE.
- **Hit rule for I/O functions.** For CONO, CONI, DATAO and DATAI, a hit requires ebus_demand=1 and ebus_cs==DEV_CS.
- **Hit rule for PI functions.** For PIserved and PIaddrIn, a hit requires ebus_demand=1, pi_level!=0 and ebus_cs[4:6]==pi_level.
- Functions 110 and 111 never hit.
- **IDLE.** On a hit, latch func and ebus_data_in.
  - CONO/DATAO: go to DONE. Load the matching cono_data or datao_data register and pulse its strobe.
  - CONI: latch coni_status into the read register and go to DONE.
  - PIaddrIn: latch pi_vector and go to DONE.
  - PIserved: pulse pi_served_stb and go to DONE.
  - DATAI with datai_valid=1: latch datai_data, pulse datai_taken, go to DONE.
  - DATAI with datai_valid=0: go to WAIT.
- **WAIT.** ebus_ack=1, ebus_xfer=0, drv.driving=0.
  - When datai_valid=1: latch data, pulse datai_taken, go to DONE.
  - If ebus_demand drops: go to IDLE with no datai_taken (abort).
- **DONE.** ebus_ack=1 and ebus_xfer=1.
  - For CONI, DATAI and PIaddrIn: drv.driving=1 and drv.data=read register.
  - Hold until ebus_demand=0, then go to IDLE. No new transaction starts before demand has been seen low.
- **Idle outputs.** drv.data=0 whenever drv.driving=0.
- **PI request.** ebus_pi is registered from pi_level every cycle. Bit pi_level is set, all others clear; all zero when the level is 0.
- **EBUS reset.** ebus_reset=1 forces IDLE, clears ack, xfer, drv and ebus_pi, and pulses dev_reset for one cycle on its rising edge. It has priority over any transaction.
- **Async reset.** rst_n=0 clears every register and output to 0, including the data registers.

## Timing

- Inputs are sampled on the rising edge of clk.
- A hit sampled at edge N gives the following at N+1:
  - ebus_ack=1.
  - Strobe pulses (cono_stb, datao_stb, datai_taken, pi_served_stb) high for N+1 only.
  - For a DONE transition: ebus_xfer=1, and read data driven on drv.
- Write data registers are valid from N+1 and held until the next write of the same kind.
- DATAI with a wait: datai_valid sampled at edge M gives xfer, data and datai_taken at M+1.
- Demand sampled low at edge K gives ack=0, xfer=0 and driving=0 at K+1.
- The earliest re-hit is sampled at K+1 and responds at K+2.
- ebus_pi has one cycle of latency from pi_level.
- If demand falls on the same edge that datai_valid rises in WAIT, the abort wins: no datai_taken.
- If ebus_reset and a hit occur on the same edge, the reset wins: no ack and no strobes.

## Test plan

- **CONO.** CONO to cs=DEV_CS with data 36'o123456_654321 → ack=1 and xfer=1 one cycle later, cono_stb one cycle, cono_data=36'o123456654321. Drop demand → ack=0 next cycle.
- **Non-matching cs.** DATAO to cs=DEV_CS+1 → ack, xfer, strobes and driving stay 0 for 10 cycles.
- **Delayed DATAI.** DATAI with datai_valid low for 5 cycles, then datai_data=36'o777000_000777 → ack for 5 cycles with xfer=0 and driving=0, then xfer=1, driving=1, drv.data=36'o777000000777 and one datai_taken pulse.
- **DATAI abort.** DATAI, then drop demand in WAIT before valid → IDLE, datai_taken never pulses.
- **PI.** pi_level=5 → ebus_pi=8'b00000100 one cycle later. PIaddrIn with cs[4:6]=5 → drv.data=pi_vector and xfer. PIserved with cs[4:6]=3 → no ack.
- **Resets.** ebus_reset during DONE → ack, xfer and drv cleared next cycle, single dev_reset pulse. rst_n low mid-WAIT → all outputs 0 immediately (asynchronous).
